// File: rtl/ps2_uart_pkg.sv
// Shared constants for the PS/2-to-UART scheduler: scan codes, ASCII values,
// state encodings and the set-2 letter/digit code tables.
package ps2_uart_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_CR      = 8'h0D;

  localparam int ARM_TIMEOUT = 16;

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} parse_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_ARM, T_WAIT} tx_state_t;

  // Index i is letter 'A'+i.
  localparam logic [7:0] LETTER_SC [0:25] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Index i is digit i.
  localparam logic [7:0] DIGIT_SC [0:9] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 make code to ASCII lookup; o_hit=0 for unmapped codes.
module ps2_ascii_lut
  import ps2_uart_pkg::*;
#(
  parameter bit LOWER_DEFAULT = 1'b1
) (
  input  logic [7:0] i_code,
  input  logic       i_shift,
  output logic       o_hit,
  output logic [7:0] o_ascii
);

  logic [7:0] w_letter_base;

  assign w_letter_base = (i_shift || !LOWER_DEFAULT) ? ASCII_UPPER_A : ASCII_LOWER_A;

  always_comb begin
    o_hit   = 1'b0;
    o_ascii = 8'h00;
    for (int i = 0; i < 26; i++) begin
      if (i_code == LETTER_SC[i]) begin
        o_hit   = 1'b1;
        o_ascii = w_letter_base + 8'(i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i_code == DIGIT_SC[i]) begin
        o_hit   = 1'b1;
        o_ascii = ASCII_ZERO + 8'(i);
      end
    end
    if (i_code == SC_SPACE) begin
      o_hit   = 1'b1;
      o_ascii = ASCII_SPACE;
    end
    if (i_code == SC_ENTER) begin
      o_hit   = 1'b1;
      o_ascii = ASCII_CR;
    end
  end

endmodule

// File: rtl/ps2_uart_sched.sv
// Scan-code parser, character FIFO and one-byte-at-a-time UART sequencer
// between the PS/2 receiver and the UART transmitter.
module ps2_uart_sched
  import ps2_uart_pkg::*;
#(
  parameter int FIFO_AW       = 3,
  parameter bit LOWER_DEFAULT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_ps2_byte,
  input  logic               i_ps2_valid,
  input  logic               i_tx_busy,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = DEPTH[FIFO_AW:0];

  parse_state_t        r_pstate;
  tx_state_t           r_tstate;
  logic                r_lshift, r_rshift;
  logic                r_push;
  logic [7:0]          r_push_data;
  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_level;
  logic                r_overflow;
  logic [7:0]          r_tx_data;
  logic                r_tx_start;
  logic [3:0]          r_arm_cnt;

  logic                w_hit;
  logic [7:0]          w_ascii;
  logic                w_full, w_pop, w_wr;

  ps2_ascii_lut #(.LOWER_DEFAULT(LOWER_DEFAULT)) u_lut (
    .i_code  (i_ps2_byte),
    .i_shift (r_lshift | r_rshift),
    .o_hit   (w_hit),
    .o_ascii (w_ascii)
  );

  assign w_full = (r_level == FULL_LVL);
  assign w_pop  = (r_tstate == T_IDLE) && (r_level != '0) && !i_tx_busy;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pstate    <= P_IDLE;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push <= 1'b0;
      if (i_ps2_valid) begin
        case (r_pstate)
          P_IDLE: begin
            if (i_ps2_byte == SC_BREAK)       r_pstate <= P_BRK;
            else if (i_ps2_byte == SC_EXT)    r_pstate <= P_EXT;
            else if (i_ps2_byte == SC_LSHIFT) r_lshift <= 1'b1;
            else if (i_ps2_byte == SC_RSHIFT) r_rshift <= 1'b1;
            else begin
              r_push      <= w_hit;
              r_push_data <= w_ascii;
            end
          end
          P_EXT:   r_pstate <= (i_ps2_byte == SC_BREAK) ? P_EXT_BRK : P_IDLE;
          P_BRK: begin
            if (i_ps2_byte == SC_LSHIFT) r_lshift <= 1'b0;
            if (i_ps2_byte == SC_RSHIFT) r_rshift <= 1'b0;
            r_pstate <= P_IDLE;
          end
          default: r_pstate <= P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tstate   <= T_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_arm_cnt  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_tstate)
        T_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_tstate   <= T_START;
          end
        end
        T_START: begin
          r_arm_cnt <= 4'(ARM_TIMEOUT - 1);
          r_tstate  <= T_ARM;
        end
        T_ARM: begin
          // A UART that never answers must not stall the queue.
          if (i_tx_busy)              r_tstate  <= T_WAIT;
          else if (r_arm_cnt == 4'd0) r_tstate  <= T_IDLE;
          else                        r_arm_cnt <= r_arm_cnt - 1'b1;
        end
        default: begin
          if (!i_tx_busy) r_tstate <= T_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;
  assign o_fifo_level = r_level;
  assign o_overflow   = r_overflow;

endmodule
